// File: rtl/rom_burst_reader_pkg.sv
// rtl/rom_burst_reader_pkg.sv - content modes, FSM states and the ROM word generator for rom_burst_reader
package rom_burst_pkg;

  localparam int MODE_ONEHOT = 0;
  localparam int MODE_THERM  = 1;
  localparam int MODE_ADDR   = 2;

  // Widest word / address the generator can describe; instances truncate to their own widths.
  localparam int ROM_MAX_W  = 64;
  localparam int ROM_MAX_AW = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Word stored at addr for the given pattern; unpopulated addresses (>= depth) read as zero.
  function automatic logic [ROM_MAX_W-1:0] rom_word(
    input logic [ROM_MAX_AW-1:0] addr,
    input int                    mode,
    input int                    depth,
    input int                    data_w
  );
    logic [ROM_MAX_W-1:0] word;
    logic [5:0]           bit_pos;
    word    = '0;
    bit_pos = 6'(addr % ROM_MAX_AW'(data_w));
    if (addr < ROM_MAX_AW'(depth)) begin
      case (mode)
        MODE_ONEHOT: word = ROM_MAX_W'(1) << bit_pos;
        // 2<<63 wraps to zero, so the top position still yields all ones
        MODE_THERM:  word = (ROM_MAX_W'(2) << bit_pos) - ROM_MAX_W'(1);
        MODE_ADDR:   word = ROM_MAX_W'(addr);
        default:     word = '0;
      endcase
    end
    return word;
  endfunction

endpackage

// File: rtl/rom_burst_reader_if.sv
// rtl/rom_burst_reader_if.sv - request/response bus of rom_burst_reader (optional ROM_BURST_PARITY_EN signals)
interface rom_burst_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_last;

`ifdef ROM_BURST_PARITY_EN
  logic              rsp_par;
  logic              err_inj;

  modport master (
    output req_valid, req_addr, req_len, rsp_ready, err_inj,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_par
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready, err_inj,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_par
  );
`else
  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
  );
`endif

endinterface

// File: rtl/rom_burst_reader_table.sv
// rtl/rom_burst_reader_table.sv - combinational ROM content generator, address in, word out
module rom_burst_table
  import rom_burst_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int MODE   = MODE_ONEHOT
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Pure function of the address; with constant parameters this folds to a fixed table.
  // In address-echo mode the cast drops address bits above DATA_W.
  always_comb data = DATA_W'(rom_word(ROM_MAX_AW'(addr), MODE, DEPTH, DATA_W));

endmodule

// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - burst-read engine over a parametrised pattern ROM (optional ROM_BURST_PARITY_EN)
module rom_burst_reader
  import rom_burst_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int MODE   = MODE_ONEHOT
) (
  input  logic               clk,
  input  logic               rst_n,
  rom_burst_reader_if.slave  bus,
  output logic               busy
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] rem;
  logic              slot_free;
  logic              accept;
  logic              load;
  logic [DATA_W-1:0] rom_data;

  // The output slot can take a new beat when it is empty or being drained this cycle.
  assign slot_free = !bus.rsp_valid || bus.rsp_ready;
  assign busy      = (state == BURST) || bus.rsp_valid;

  rom_burst_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .MODE   (MODE)
  ) u_table (
    .addr (cur_addr),
    .data (rom_data)
  );

  // Next-state, request acceptance and beat-load decode.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    load          = 1'b0;
    bus.req_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = slot_free;
        if (bus.req_valid && slot_free) begin
          accept    = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (slot_free) begin
          load = 1'b1;
          if (rem == '0) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst address and remaining-beat counter; the address wraps around the address space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      rem      <= '0;
    end else if (accept) begin
      cur_addr <= bus.req_addr;
      rem      <= bus.req_len;
    end else if (load) begin
      cur_addr <= cur_addr + 1'b1;
      rem      <= rem - 1'b1;
    end
  end

  // One-entry output slot: load a beat when free, otherwise hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_addr  <= '0;
      bus.rsp_last  <= 1'b0;
`ifdef ROM_BURST_PARITY_EN
      bus.rsp_par   <= 1'b0;
`endif
    end else if (load) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_data  <= rom_data;
      bus.rsp_addr  <= cur_addr;
      bus.rsp_last  <= (rem == '0);
`ifdef ROM_BURST_PARITY_EN
      bus.rsp_par   <= (^rom_data) ^ bus.err_inj;
`endif
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule
